// File: rtl/inst_fetch_unit_if.sv
// Memory-controller side of the instruction fetch unit.
// The fetch unit takes the master modport; the memory model or controller takes slave.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              mem_req_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_ack_in;
  logic [INST_W-1:0] mem_inst_in;

  modport master (
    output mem_req_out,
    output mem_addr_out,
    input  mem_ack_in,
    input  mem_inst_in
  );

  modport slave (
    input  mem_req_out,
    input  mem_addr_out,
    output mem_ack_in,
    output mem_inst_in
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch unit: direct-mapped I-cache, show-ahead queue, single-miss engine.
// Define ICACHE_FLUSH_EN to add the icache_flush_in invalidate port.
module inst_fetch_unit #(
  parameter int ADDR_W       = 32,
  parameter int INST_W       = 32,
  parameter int ICACHE_IDX_W = 8,
  parameter int IQ_DEPTH     = 8,
  parameter int IQ_PTR_W     = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  inst_fetch_unit_if.master mem,
  output logic [ADDR_W-1:0] pc_to_predictor,
  output logic [INST_W-1:0] inst_to_predictor,
  input  logic              predict_jump_in,
  input  logic [ADDR_W-1:0] predict_target_in,
  input  logic              dispatch_ready_in,
  output logic              inst_valid_out,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc_out,
  output logic              pred_jump_out,
  output logic [ADDR_W-1:0] fallthrough_pc_out,
  input  logic              rollback_in,
  input  logic [ADDR_W-1:0] rollback_pc_in
`ifdef ICACHE_FLUSH_EN
  ,
  input  logic              icache_flush_in
`endif
);

  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = ADDR_W - ICACHE_IDX_W - 2;
  localparam logic [IQ_PTR_W:0] IQ_FULL = (IQ_PTR_W+1)'(IQ_DEPTH);

  typedef enum logic {IDLE, MISS} state_t;

  state_t state_q, state_nx;
  logic              req_q, req_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [ADDR_W-1:0] pc_q;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [INST_W-1:0] data_q [LINES];

  logic [INST_W-1:0] iq_inst [IQ_DEPTH];
  logic [ADDR_W-1:0] iq_pc   [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] iq_pj;
  logic [IQ_PTR_W-1:0] head_q, tail_q;
  logic [IQ_PTR_W:0]   cnt_q;

  logic [ICACHE_IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0]        pc_tag;
  logic hit, fill, flush, push, pop;

`ifdef ICACHE_FLUSH_EN
  assign flush = icache_flush_in;
`else
  assign flush = 1'b0;
`endif

  assign idx      = pc_q[ICACHE_IDX_W+1:2];
  assign pc_tag   = pc_q[ADDR_W-1:ICACHE_IDX_W+2];
  assign fill_idx = addr_q[ICACHE_IDX_W+1:2];
  assign hit      = valid_q[idx] && (tag_q[idx] == pc_tag);

  assign inst_valid_out = (cnt_q != '0);
  assign push = rdy_in && !rollback_in && !flush && (state_q == IDLE)
             && hit && (cnt_q != IQ_FULL);
  assign pop  = rdy_in && !rollback_in && inst_valid_out
             && dispatch_ready_in;

  assign pc_to_predictor    = pc_q;
  assign inst_to_predictor  = hit ? data_q[idx] : '0;
  assign inst_out           = iq_inst[head_q];
  assign inst_pc_out        = iq_pc[head_q];
  assign pred_jump_out      = iq_pj[head_q];
  assign fallthrough_pc_out = iq_pc[head_q] + ADDR_W'(4);

  assign mem.mem_req_out  = req_q;
  assign mem.mem_addr_out = addr_q;

  always_comb begin
    state_nx = state_q;
    req_nx   = req_q;
    addr_nx  = addr_q;
    fill     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rdy_in && !rollback_in && !hit) begin
          state_nx = MISS;
          req_nx   = 1'b1;
          addr_nx  = {pc_q[ADDR_W-1:2], 2'b00};
        end
      end
      MISS: begin
        // a rollback does not cancel the fill; a flush does
        if (rdy_in && mem.mem_ack_in) begin
          state_nx = IDLE;
          req_nx   = 1'b0;
          fill     = !flush;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else if (rdy_in) begin
      state_q <= state_nx;
      req_q   <= req_nx;
      addr_q  <= addr_nx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pc_q <= RESET_PC;
    end else if (rdy_in) begin
      if (rollback_in)
        pc_q <= rollback_pc_in;
      else if (push)
        pc_q <= predict_jump_in ? predict_target_in
                                : pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (rdy_in) begin
      if (flush)
        valid_q <= '0;
      else if (fill)
        valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill) begin
      tag_q[fill_idx]  <= addr_q[ADDR_W-1:ICACHE_IDX_W+2];
      data_q[fill_idx] <= mem.mem_inst_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (rdy_in) begin
      if (rollback_in) begin
        head_q <= tail_q;
        cnt_q  <= '0;
      end else begin
        if (push)
          tail_q <= tail_q + IQ_PTR_W'(1);
        if (pop)
          head_q <= head_q + IQ_PTR_W'(1);
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + (IQ_PTR_W+1)'(1);
          2'b01:   cnt_q <= cnt_q - (IQ_PTR_W+1)'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      iq_inst[tail_q] <= data_q[idx];
      iq_pc[tail_q]   <= pc_q;
      iq_pj[tail_q]   <= predict_jump_in;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Random-stimulus bench for inst_fetch_unit against a queue/array model.
// Memory returns memfn(addr) after a random latency.
module tb_inst_fetch_unit;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] pc_to_predictor;
  logic [31:0] inst_to_predictor;
  logic        predict_jump_in = 1'b0;
  logic [31:0] predict_target_in = '0;
  logic        dispatch_ready_in = 1'b0;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic        pred_jump_out;
  logic [31:0] fallthrough_pc_out;
  logic        rollback_in = 1'b0;
  logic [31:0] rollback_pc_in = '0;
`ifdef ICACHE_FLUSH_EN
  logic        icache_flush_in = 1'b0;
`endif

  inst_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) mem_if();

  inst_fetch_unit dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .mem                (mem_if),
    .pc_to_predictor    (pc_to_predictor),
    .inst_to_predictor  (inst_to_predictor),
    .predict_jump_in    (predict_jump_in),
    .predict_target_in  (predict_target_in),
    .dispatch_ready_in  (dispatch_ready_in),
    .inst_valid_out     (inst_valid_out),
    .inst_out           (inst_out),
    .inst_pc_out        (inst_pc_out),
    .pred_jump_out      (pred_jump_out),
    .fallthrough_pc_out (fallthrough_pc_out),
    .rollback_in        (rollback_in),
    .rollback_pc_in     (rollback_pc_in)
`ifdef ICACHE_FLUSH_EN
    ,
    .icache_flush_in    (icache_flush_in)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pj;
  } ent_t;

  // model: line_of[index] = word address currently cached at that index
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_busy;
  ent_t        mq[$];
  logic [31:0] line_of[int];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  function automatic bit m_hit();
    int i;
    i = int'(m_pc[9:2]);
    return line_of.exists(i) && (line_of[i] == {m_pc[31:2], 2'b00});
  endfunction

  task automatic m_reset();
    m_pc   = 32'h0;
    m_addr = 32'h0;
    m_busy = 1'b0;
    mq.delete();
    line_of.delete();
  endtask

  task automatic m_step();
    bit   h, pu, po, was_busy, fl;
    ent_t e;
    if (!rst_in) begin
      m_reset();
      return;
    end
    if (!rdy_in) return;
`ifdef ICACHE_FLUSH_EN
    fl = icache_flush_in;
`else
    fl = 1'b0;
`endif
    h = m_hit();
    was_busy = m_busy;
    if (rollback_in) begin
      mq.delete();
    end else begin
      po = (mq.size() != 0) && dispatch_ready_in;
      pu = !was_busy && h && (mq.size() < 8) && !fl;
      if (po) void'(mq.pop_front());
      if (!was_busy && !h) begin
        m_busy = 1'b1;
        m_addr = {m_pc[31:2], 2'b00};
      end
      if (pu) begin
        e.inst = memfn(m_pc);
        e.pc   = m_pc;
        e.pj   = predict_jump_in;
        mq.push_back(e);
        m_pc = predict_jump_in ? predict_target_in : m_pc + 32'd4;
      end
    end
    if (fl) line_of.delete();
    if (was_busy && mem_if.mem_ack_in) begin
      if (!fl) line_of[int'(m_addr[9:2])] = m_addr;
      m_busy = 1'b0;
    end
    if (rollback_in) m_pc = rollback_pc_in;
  endtask

  task automatic m_compare(input bit force_addr);
    chk("valid", {31'b0, inst_valid_out}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("inst", inst_out, mq[0].inst);
      chk("inst_pc", inst_pc_out, mq[0].pc);
      chk("pred_jump", {31'b0, pred_jump_out}, {31'b0, mq[0].pj});
      chk("fallthru", fallthrough_pc_out, mq[0].pc + 32'd4);
    end
    chk("mem_req", {31'b0, mem_if.mem_req_out}, {31'b0, m_busy});
    if (m_busy || force_addr) chk("mem_addr", mem_if.mem_addr_out, m_addr);
    chk("pc_pred", pc_to_predictor, m_pc);
    chk("inst_pred", inst_to_predictor, m_hit() ? memfn(m_pc) : 32'h0);
  endtask

  int wcnt = 2;
  int dprob;

  initial begin
    mem_if.mem_ack_in  = 1'b0;
    mem_if.mem_inst_in = '0;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    m_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    m_compare(1'b1);

    for (int cyc = 0; cyc < 8000; cyc++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      rst_in = !(cyc == 4000 || cyc == 4001);
      case ((cyc / 300) % 4)
        0:       dprob = 10;
        1:       dprob = 50;
        2:       dprob = 95;
        default: dprob = 0;
      endcase
      dispatch_ready_in = ($urandom_range(0, 99) < dprob);
      predict_jump_in   = ($urandom_range(0, 4) == 0);
      predict_target_in = 32'($urandom_range(0, 511)) << 2;
      rollback_in       = ($urandom_range(0, 59) == 0);
      rollback_pc_in    = 32'($urandom_range(0, 511)) << 2;
`ifdef ICACHE_FLUSH_EN
      icache_flush_in   = ($urandom_range(0, 99) == 0);
`endif
      mem_if.mem_ack_in = 1'b0;
      if (rst_in && rdy_in && mem_if.mem_req_out) begin
        if (wcnt == 0) begin
          mem_if.mem_ack_in = 1'b1;
          wcnt = $urandom_range(0, 3);
        end else begin
          wcnt--;
        end
      end
      mem_if.mem_inst_in = mem_if.mem_ack_in ? memfn(mem_if.mem_addr_out)
                                             : 32'($urandom);
      m_step();
      @(negedge clk_in);
      m_compare(cyc == 4001);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
